sample_stash: RTL and testbench

SAMPLE_STASH -- requirements
Module: sample_stash

---
 rtl/sample_stash_if.sv | 31 +++
 rtl/sample_stash.sv | 109 ++++++++++
 tb/tb_sample_stash.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_stash_if.sv
// Sample/view bus of the sample stash: producer and navigation inputs,
// live or viewed sample and occupancy status back to the controller.
interface sample_stash_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic             prev_sample;
    logic             clear;
    logic [WIDTH-1:0] sample_out;
    logic [IW-1:0]    view_index;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             dropped;

    modport master (
        output sample_in, sample_in_valid, next_sample, prev_sample, clear,
        input  sample_out, view_index, count, full, empty, dropped
    );

    modport slave (
        input  sample_in, sample_in_valid, next_sample, prev_sample, clear,
        output sample_out, view_index, count, full, empty, dropped
    );
endinterface

// File: rtl/sample_stash.sv
// Circular sample buffer with a navigable view of the stored history and a
// live bypass of the incoming sample.
module sample_stash #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter bit OVERWRITE = 1'b1
) (
    input logic           clk,
    input logic           reset,
    sample_stash_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [IW:0]   DEPTH_W  = (IW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    oldest_q, oldest_d;
    logic [IW-1:0]    wr_q, wr_d;
    logic [IW-1:0]    view_q, view_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dropped_q, dropped_d;
    logic             mem_we;
    logic             is_full, is_empty;
    logic [IW:0]      rd_sum;
    logic [IW-1:0]    rd_addr;
    logic [CW-1:0]    view_ext;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + IW'(1);
    endfunction

    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);
    assign view_ext = CW'(view_q);

    // Viewed entry is relative to the oldest pointer, wrapped at DEPTH.
    assign rd_sum  = {1'b0, oldest_q} + {1'b0, view_q};
    assign rd_addr = (rd_sum >= DEPTH_W) ? IW'(rd_sum - DEPTH_W) : rd_sum[IW-1:0];

    always_comb begin
        oldest_d  = oldest_q;
        wr_d      = wr_q;
        view_d    = view_q;
        count_d   = count_q;
        dropped_d = 1'b0;
        mem_we    = 1'b0;
        if (bus.clear) begin
            oldest_d = '0;
            wr_d     = '0;
            view_d   = '0;
            count_d  = '0;
        end else begin
            // Navigation works on the pre-write count; a write never moves the view.
            if (!is_empty && (bus.next_sample ^ bus.prev_sample)) begin
                if (bus.next_sample) begin
                    view_d = (view_ext == count_q - CW'(1)) ? '0 : view_q + IW'(1);
                end else begin
                    view_d = (view_q == '0) ? IW'(count_q - CW'(1)) : view_q - IW'(1);
                end
            end
            if (bus.sample_in_valid) begin
                if (!is_full) begin
                    mem_we  = 1'b1;
                    wr_d    = ptr_inc(wr_q);
                    count_d = count_q + CW'(1);
                end else if (OVERWRITE) begin
                    mem_we   = 1'b1;
                    wr_d     = ptr_inc(wr_q);
                    oldest_d = ptr_inc(oldest_q);
                end else begin
                    dropped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oldest_q  <= '0;
            wr_q      <= '0;
            view_q    <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            oldest_q  <= oldest_d;
            wr_q      <= wr_d;
            view_q    <= view_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage is never flushed; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wr_q] <= bus.sample_in;
        end
    end

    assign bus.sample_out = bus.sample_in_valid ? bus.sample_in :
                            is_empty            ? '0 : mem_q[rd_addr];
    assign bus.view_index = view_q;
    assign bus.count      = count_q;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.dropped    = dropped_q;
endmodule

// File: tb/tb_sample_stash.sv
// Bench for sample_stash: a drop-policy and an overwrite-policy instance
// driven in lockstep and compared against a list-based model.
module tb_sample_stash;
    localparam int W = 8;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_stash_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    sample_stash_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    sample_stash #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_drop (
        .clk(clk), .reset(reset), .bus(if0.slave));
    sample_stash #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ovw (
        .clk(clk), .reset(reset), .bus(if1.slave));

    int n_checks = 0;
    int n_errors = 0;

    // Model: logical contents in arrival order (index 0 = oldest).
    logic [W-1:0] m_data [2][D];
    int           m_cnt  [2];
    int           m_view [2];
    bit           m_drop [2];

    bit           c_rst, c_clr, c_vld, c_nx, c_pv;
    logic [W-1:0] c_din;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input int m, input bit ovw);
        if (c_rst || c_clr) begin
            m_cnt[m]  = 0;
            m_view[m] = 0;
            m_drop[m] = 0;
        end else begin
            m_drop[m] = 0;
            if (m_cnt[m] > 0 && (c_nx != c_pv)) begin
                if (c_nx) m_view[m] = (m_view[m] + 1) % m_cnt[m];
                else      m_view[m] = (m_view[m] == 0) ? m_cnt[m] - 1 : m_view[m] - 1;
            end
            if (c_vld) begin
                if (m_cnt[m] < D) begin
                    m_data[m][m_cnt[m]] = c_din;
                    m_cnt[m]++;
                end else if (ovw) begin
                    for (int i = 0; i < D - 1; i++) m_data[m][i] = m_data[m][i+1];
                    m_data[m][D-1] = c_din;
                end else begin
                    m_drop[m] = 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int m, input logic [W-1:0] so, input logic [2:0] vi,
                             input logic [3:0] cnt, input logic f, input logic e, input logic dr);
        logic [W-1:0] exp_out;
        exp_out = c_vld ? c_din : (m_cnt[m] == 0) ? '0 : m_data[m][m_view[m]];
        check($sformatf("u%0d.sample_out", m), 32'(so), 32'(exp_out));
        check($sformatf("u%0d.view_index", m), 32'(vi), 32'(m_view[m]));
        check($sformatf("u%0d.count", m), 32'(cnt), 32'(m_cnt[m]));
        check($sformatf("u%0d.full", m), 32'(f), 32'(m_cnt[m] == D));
        check($sformatf("u%0d.empty", m), 32'(e), 32'(m_cnt[m] == 0));
        check($sformatf("u%0d.dropped", m), 32'(dr), 32'(m_drop[m]));
    endtask

    task automatic apply(input bit r, input bit c, input bit v, input logic [W-1:0] d,
                         input bit n, input bit p);
        c_rst = r; c_clr = c; c_vld = v; c_din = d; c_nx = n; c_pv = p;
        reset = r;
        if0.clear = c; if0.sample_in_valid = v; if0.sample_in = d;
        if0.next_sample = n; if0.prev_sample = p;
        if1.clear = c; if1.sample_in_valid = v; if1.sample_in = d;
        if1.next_sample = n; if1.prev_sample = p;
    endtask

    task automatic drive(input bit r, input bit c, input bit v, input logic [W-1:0] d,
                         input bit n, input bit p);
        apply(r, c, v, d, n, p);
        #3;
        check_dut(0, if0.sample_out, if0.view_index, if0.count, if0.full, if0.empty, if0.dropped);
        check_dut(1, if1.sample_out, if1.view_index, if1.count, if1.full, if1.empty, if1.dropped);
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0, 1'b0);
        model_update(1, 1'b1);
        #1;
    endtask

    task automatic cycle(input bit r, input bit c, input bit v, input logic [W-1:0] d,
                         input bit n, input bit p);
        drive(r, c, v, d, n, p);
        step();
    endtask

    task automatic peek();
        apply(0, 0, 0, '0, 0, 0);
        #1;
    endtask

    initial begin
        apply(1, 0, 0, '0, 0, 0);
        @(posedge clk);
        model_update(0, 1'b0);
        model_update(1, 1'b1);
        #1;

        // Reset state
        cycle(1, 0, 0, '0, 0, 0);
        peek();
        check("rst.count", 32'(if1.count), 0);
        check("rst.empty", 32'(if1.empty), 1);
        check("rst.full", 32'(if1.full), 0);
        check("rst.sample_out", 32'(if1.sample_out), 0);
        check("rst.dropped", 32'(if0.dropped), 0);

        // Three writes, forward navigation with wrap
        cycle(0, 0, 1, 8'h11, 0, 0);
        cycle(0, 0, 1, 8'h22, 0, 0);
        cycle(0, 0, 1, 8'h33, 0, 0);
        peek();
        check("w3.count", 32'(if1.count), 3);
        check("w3.view", 32'(if1.view_index), 0);
        check("w3.out", 32'(if1.sample_out), 32'h11);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(0, 0, 0, '0, 1, 0);
        peek();
        check("next2.out", 32'(if1.sample_out), 32'h33);
        cycle(0, 0, 0, '0, 1, 0);
        peek();
        check("next_wrap.out", 32'(if1.sample_out), 32'h11);
        cycle(0, 0, 0, '0, 0, 1);
        peek();
        check("prev_wrap.view", 32'(if1.view_index), 2);
        check("prev_wrap.out", 32'(if1.sample_out), 32'h33);
        cycle(0, 0, 0, '0, 1, 1);
        peek();
        check("both.view", 32'(if1.view_index), 2);

        // Nine writes into a depth-8 buffer under both policies
        cycle(1, 0, 0, '0, 0, 0);
        for (int i = 1; i <= 9; i++) cycle(0, 0, 1, W'(i), 0, 0);
        peek();
        check("ovw.full", 32'(if1.full), 1);
        check("ovw.count", 32'(if1.count), 8);
        check("ovw.v0", 32'(if1.sample_out), 2);
        check("drop.count", 32'(if0.count), 8);
        check("drop.pulse", 32'(if0.dropped), 1);
        cycle(0, 0, 0, '0, 0, 1);
        peek();
        check("drop.pulse_end", 32'(if0.dropped), 0);
        check("ovw.v7", 32'(if1.sample_out), 9);
        check("drop.v7", 32'(if0.sample_out), 8);

        // Live bypass combined with a clear of the full buffer
        drive(0, 1, 1, 8'hAB, 0, 0);
        check("bypass.out", 32'(if0.sample_out), 32'hAB);
        step();
        peek();
        check("clr.count", 32'(if0.count), 0);
        check("clr.empty", 32'(if0.empty), 1);
        check("clr.out", 32'(if0.sample_out), 0);
        check("clr.dropped", 32'(if0.dropped), 0);

        // Reset during a write to a full buffer
        for (int i = 0; i < D; i++) cycle(0, 0, 1, W'(8'h40 + i), 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        cycle(1, 0, 1, 8'h77, 1, 0);
        peek();
        check("rstw.count", 32'(if0.count), 0);
        check("rstw.view", 32'(if1.view_index), 0);
        check("rstw.empty", 32'(if1.empty), 1);
        check("rstw.full", 32'(if1.full), 0);
        check("rstw.dropped", 32'(if0.dropped), 0);
        check("rstw.out", 32'(if1.sample_out), 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int sel;
            bit r, c, v, n, p;
            sel = int'($urandom_range(0, 199));
            r = (sel == 0);
            c = (sel >= 1 && sel <= 3);
            v = ($urandom_range(0, 9) < 6);
            n = ($urandom_range(0, 9) < 3);
            p = ($urandom_range(0, 9) < 3);
            cycle(r, c, v, W'($urandom), n, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
